// File: rtl/axis_ad7276_pkg.sv
// Shared definitions for the AD7276 stream path (interpolator and decimator).
// Holds the emit FSM state type and the default datapath widths.
package axis_ad7276_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int unsigned AD7276_DATA_WIDTH  = 12;
    localparam int unsigned AD7276_RATIO_WIDTH = 32;

endpackage

// File: rtl/axis_interpolator.sv
// AXI-Stream upsampler: each accepted sample is emitted interp_reg+1 times.
// Define INTERP_ZERO_STUFF_EN to zero-stuff beats 2..N instead of sample-and-hold.
module axis_interpolator
    import axis_ad7276_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = AD7276_DATA_WIDTH,
    parameter int unsigned RATIO_WIDTH = AD7276_RATIO_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RATIO_WIDTH-1:0] interp_reg,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy
);

    state_t                 state;
    state_t                 state_nxt;
    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] ratio_lat;
    logic [DATA_WIDTH-1:0]  hold_reg;
    logic [DATA_WIDTH-1:0]  fill_data;
    logic                   last;
    logic                   accept;
    logic                   out_hs;

    // cnt stops at ratio_lat, so an all-ones ratio never wraps before last.
    assign last          = (cnt == ratio_lat);
    assign m_axis_tvalid = (state == EMIT);
    assign m_axis_tlast  = m_axis_tvalid & last;
    assign busy          = m_axis_tvalid;
    assign s_axis_tready = !m_axis_tvalid | (m_axis_tready & last);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign out_hs        = m_axis_tvalid & m_axis_tready;

`ifdef INTERP_ZERO_STUFF_EN
    assign fill_data = '0;
`else
    assign fill_data = hold_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EMIT;
            EMIT:    if (out_hs && last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            ratio_lat    <= '0;
            hold_reg     <= '0;
            m_axis_tdata <= '0;
        end else if (accept) begin
            hold_reg     <= s_axis_tdata;
            m_axis_tdata <= s_axis_tdata;
            ratio_lat    <= interp_reg;
            cnt          <= '0;
        end else if (out_hs && !last) begin
            cnt          <= cnt + 1'b1;
            m_axis_tdata <= fill_data;
        end
    end

endmodule

// File: tb/tb_axis_interpolator.sv
// Self-checking bench for axis_interpolator: directed scenarios plus randomized
// traffic, scored against a queue model of the expected output beats.
module tb_axis_interpolator;

    localparam int unsigned DW = 12;
    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] interp_reg = '0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          busy;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    logic          rand_rdy = 1'b0;

    axis_interpolator #(.DATA_WIDTH(DW), .RATIO_WIDTH(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .interp_reg    (interp_reg),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Model: the queue holds every beat still owed downstream. A group may only
    // be accepted when nothing is owed, or the last owed beat leaves this cycle.
    task automatic monitor(output logic acc);
        logic exp_rdy;
        acc = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            return;
        end
        exp_rdy = (exp_q.size() == 0) || (m_axis_tready && exp_q.size() == 1);
        check("m_tvalid", m_axis_tvalid, exp_q.size() != 0);
        check("busy", busy, exp_q.size() != 0);
        check("s_tready", s_axis_tready, exp_rdy);
        if (exp_q.size() != 0) begin
            check("m_tdata", m_axis_tdata, exp_q[0]);
            check("m_tlast", m_axis_tlast, exp_q.size() == 1);
            if (m_axis_tready) void'(exp_q.pop_front());
        end else begin
            check("m_tlast_idle", m_axis_tlast, 0);
        end
        if (s_axis_tvalid && exp_rdy) begin
            acc = 1'b1;
            for (int unsigned i = 0; i <= 32'(interp_reg); i++) begin
`ifdef INTERP_ZERO_STUFF_EN
                exp_q.push_back(i == 0 ? s_axis_tdata : '0);
`else
                exp_q.push_back(s_axis_tdata);
`endif
            end
        end
    endtask

    task automatic tick(output logic acc);
        @(negedge clk);
        monitor(acc);
        @(posedge clk);
        #1;
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        logic acc;
        tick(acc);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] r);
        logic acc;
        int unsigned n;
        n = 0;
        s_axis_tdata  = d;
        interp_reg    = r;
        s_axis_tvalid = 1'b1;
        do begin
            tick(acc);
            n++;
        end while (!acc && n < 400);
        if (!acc) check("send_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 0, 1);
        step();
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tlast"}, m_axis_tlast, 0);
        check({tag, "_tdata"}, m_axis_tdata, 0);
        check({tag, "_s_tready"}, s_axis_tready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");

        // 1: pass-through, back-to-back
        send(12'd1, 4'd0);
        send(12'd2, 4'd0);
        send(12'd3, 4'd0);
        drain();

        // 2: ratio 3
        send(12'hABC, 4'd3);
        drain();

        // 3: output stall pattern
        send(12'h5A5, 4'd2);
        foreach (pat[i]) begin
            m_axis_tready = pat[i];
            step();
        end
        m_axis_tready = 1'b1;
        drain();

        // 4: continuous input, ratio 1
        send(12'h00A, 4'd1);
        send(12'h00B, 4'd1);
        send(12'h00C, 4'd1);
        drain();

        // 5: interp_reg changes mid-group
        send(12'h123, 4'd3);
        step();
        interp_reg = 4'd1;
        step();
        send(12'h456, 4'd1);
        drain();

        // 6: reset mid-group, then a fresh group
        send(12'h777, 4'd4);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_state("midrst");
        send(12'h321, 4'd4);
        drain();

        // all-ones ratio: 16 beats without counter wrap
        send(12'hFED, 4'hF);
        drain();

        // randomized traffic with output backpressure and input gaps
        rand_rdy = 1'b1;
        for (int unsigned k = 0; k < 60; k++) begin
            d = DW'($urandom);
            r = (k % 10 == 9) ? 4'hF : RW'($urandom_range(0, 15));
            send(d, r);
            interp_reg = RW'($urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_rdy = 1'b0;
        m_axis_tready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
